// File: rtl/cpu_seg_display.sv
// -----------------------------------------------------------------------------
// cpu_seg_display
//   Shows one 32-bit value as eight hex digits on a time-multiplexed,
//   active-low 7-segment display. The value is either the CPU syscall display
//   register or the CPU cycle counter. A debounced push button toggles between
//   the two. CPU halt is latched, and the cycle count is frozen at the moment
//   of halt.
//
// Parameters
//   SCAN_DIV    clk cycles per digit slot (>=2)
//   DEBOUNCE    clk cycles mode_btn must be stable before it is accepted (>=1)
//
// Ports
//   clk          in   system clock; all logic runs on posedge
//   clr          in   synchronous active-low reset
//   display      in   [31:0] CPU syscall display value
//   cycle_count  in   [31:0] CPU cycle counter
//   halt         in   CPU halt flag
//   mode_btn     in   raw asynchronous push button, active-high
//   an           out  [7:0] digit enables, active-low, an[0] = rightmost digit
//   seg          out  [7:0] {dp,g,f,e,d,c,b,a}, active-low
//   halted_led   out  sticky halt indicator
// -----------------------------------------------------------------------------
module cpu_seg_display #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 1000000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] display,
   input  logic [31:0] cycle_count,
   input  logic        halt,
   input  logic        mode_btn,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        halted_led
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE + 1);

   typedef enum logic {
      MODE_DISP = 1'b0,
      MODE_CYC  = 1'b1
   } mode_e;

   // Hex digit to segment pattern {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   mode_e          mode_q;
   logic [PW-1:0]  presc_q, presc_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    frame_q, frame_d;
   logic           halt_l_q, halt_l_d;
   logic [31:0]    frozen_q, frozen_d;
   logic           sync1_q, sync2_q;
   logic           acc_q, acc_d;
   logic [DW-1:0]  db_cnt_q, db_cnt_d;
   logic [7:0]     an_q, an_d;
   logic [7:0]     seg_q, seg_d;

   logic           tick;
   logic           acc_rise;
   logic [31:0]    src;
   logic [3:0]     nib;

   always_comb begin
      // Digit-slot prescaler and digit index.
      tick    = (presc_q == PW'(SCAN_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = tick ? idx_q + 3'd1 : idx_q;

      // The frame is captured only as digit 7 finishes, so a frame never
      // mixes two source values and mode changes show at the 7->0 wrap.
      src     = (mode_q == MODE_CYC) ? (halt_l_q ? frozen_q : cycle_count) : display;
      frame_d = (tick && idx_q == 3'd7) ? src : frame_q;

      // Halt is sticky; the count is frozen on the first halt edge only.
      halt_l_d = halt_l_q | halt;
      frozen_d = (halt && !halt_l_q) ? cycle_count : frozen_q;

      // Debounce: the counter runs only while the synchronized level differs
      // from the accepted one; any agreement restarts it.
      acc_d    = acc_q;
      db_cnt_d = '0;
      if (sync2_q != acc_q) begin
         if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
            acc_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      acc_rise = acc_d & ~acc_q;

      // Display drivers, registered below for one cycle of latency.
      nib   = frame_q[{idx_q, 2'b00} +: 4];
      an_d  = ~(8'b0000_0001 << idx_q);
      seg_d = {~(halt_l_q && idx_q == 3'd0), hex7(nib)};
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         presc_q  <= '0;
         idx_q    <= '0;
         frame_q  <= '0;
         halt_l_q <= 1'b0;
         frozen_q <= '0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         acc_q    <= 1'b0;
         db_cnt_q <= '0;
         an_q     <= 8'hFE;
         seg_q    <= 8'hC0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         frame_q  <= frame_d;
         halt_l_q <= halt_l_d;
         frozen_q <= frozen_d;
         sync1_q  <= mode_btn;
         sync2_q  <= sync1_q;
         acc_q    <= acc_d;
         db_cnt_q <= db_cnt_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   // Display source FSM: only a press (rising accepted level) toggles it.
   always_ff @(posedge clk) begin
      if (!clr) begin
         mode_q <= MODE_DISP;
      end else if (acc_rise) begin
         mode_q <= (mode_q == MODE_DISP) ? MODE_CYC : MODE_DISP;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign halted_led = halt_l_q;

endmodule
